// File: rtl/lsu_mem_pkg.sv
// Shared types for the LSU memory arbiter: channel FSM states and owner-index sizing.
package lsu_mem_pkg;

  localparam int STATE_BITS = 3;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE        = 3'd0,
    READ_WAIT   = 3'd1,
    WRITE_WAIT  = 3'd2,
    READ_RELAY  = 3'd3,
    WRITE_RELAY = 3'd4
  } chan_state_t;

  // Width of a consumer index; never zero so a single-bit owner still exists.
  function automatic int owner_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority picker: first set request at or after start, wrapping modulo N.
module rr_priority_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [N-1:0] grant,
  output logic [W-1:0] index,
  output logic         found
);

  logic [W:0] pos;

  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = {1'b0, start} + (W+1)'(i);
      if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
      if (!found && req[pos[W-1:0]]) begin
        found              = 1'b1;
        index              = pos[W-1:0];
        grant[pos[W-1:0]]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_mem_arbiter.sv
// Round-robin scheduler sharing NUM_CHANNELS memory channels among NUM_CONSUMERS
// LSU/fetcher consumers; each consumer is held by at most one channel at a time.
module lsu_mem_arbiter
  import lsu_mem_pkg::*;
#(
  parameter int NUM_CONSUMERS = 4,
  parameter int NUM_CHANNELS  = 2,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                  mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                  mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_read_data,
  output logic [NUM_CHANNELS-1:0]                  mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]   mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]   mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                  mem_write_ready,
  output logic [NUM_CHANNELS-1:0][STATE_BITS-1:0]  debug_chan_state
);

  // Handshakes: consumers raise valid with stable payload and hold it until ready;
  // ready then stays high until valid drops, and falls on the edge after that.
  // Channels raise mem valid with stable payload; a mem ready seen in a WAIT state
  // completes the request and mem valid falls on the same edge.

  localparam int OW = owner_bits(NUM_CONSUMERS);

  chan_state_t              state [NUM_CHANNELS];
  logic [OW-1:0]            owner [NUM_CHANNELS];
  logic [NUM_CONSUMERS-1:0] busy;
  logic [OW-1:0]            rr_ptr;

  logic [NUM_CONSUMERS-1:0] eligible;
  logic [NUM_CHANNELS-1:0]  take;
  logic [OW-1:0]            take_idx [NUM_CHANNELS];
  logic                     any_take;
  logic [OW-1:0]            rr_next;

  assign eligible = (consumer_read_valid | consumer_write_valid) & ~busy;

  // Each channel picks from what earlier channels left over, all from the same rr_ptr.
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic [NUM_CONSUMERS-1:0] req_in;
    logic [NUM_CONSUMERS-1:0] req_out;
    logic [NUM_CONSUMERS-1:0] onehot;
    logic [OW-1:0]            idx;
    logic                     found;
    logic                     take_l;

    if (c == 0) begin : g_first
      assign req_in = eligible;
    end else begin : g_next
      assign req_in = g_chan[c-1].req_out;
    end

    rr_priority_pick #(
      .N (NUM_CONSUMERS),
      .W (OW)
    ) u_pick (
      .req   (req_in),
      .start (rr_ptr),
      .grant (onehot),
      .index (idx),
      .found (found)
    );

    assign take_l              = (state[c] == IDLE) && found;
    assign req_out             = take_l ? (req_in & ~onehot) : req_in;
    assign take[c]             = take_l;
    assign take_idx[c]         = idx;
    assign debug_chan_state[c] = state[c];
  end

  always_comb begin
    any_take = 1'b0;
    rr_next  = rr_ptr;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (take[c]) begin
        any_take = 1'b1;
        rr_next  = (take_idx[c] == OW'(NUM_CONSUMERS - 1)) ? '0 : take_idx[c] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy                 <= '0;
      rr_ptr               <= '0;
      consumer_read_ready  <= '0;
      consumer_read_data   <= '0;
      consumer_write_ready <= '0;
      mem_read_valid       <= '0;
      mem_read_address     <= '0;
      mem_write_valid      <= '0;
      mem_write_address    <= '0;
      mem_write_data       <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state[c] <= IDLE;
        owner[c] <= '0;
      end
    end else begin
      if (any_take) rr_ptr <= rr_next;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        case (state[c])
          IDLE: begin
            if (take[c]) begin
              owner[c]          <= take_idx[c];
              busy[take_idx[c]] <= 1'b1;
              // Reads win when a consumer asks for both; its write stays pending.
              if (consumer_read_valid[take_idx[c]]) begin
                state[c]            <= READ_WAIT;
                mem_read_valid[c]   <= 1'b1;
                mem_read_address[c] <= consumer_read_address[take_idx[c]];
              end else begin
                state[c]             <= WRITE_WAIT;
                mem_write_valid[c]   <= 1'b1;
                mem_write_address[c] <= consumer_write_address[take_idx[c]];
                mem_write_data[c]    <= consumer_write_data[take_idx[c]];
              end
            end
          end
          READ_WAIT: begin
            if (mem_read_ready[c]) begin
              state[c]                      <= READ_RELAY;
              mem_read_valid[c]             <= 1'b0;
              consumer_read_data[owner[c]]  <= mem_read_data[c];
              consumer_read_ready[owner[c]] <= 1'b1;
            end
          end
          WRITE_WAIT: begin
            if (mem_write_ready[c]) begin
              state[c]                       <= WRITE_RELAY;
              mem_write_valid[c]             <= 1'b0;
              consumer_write_ready[owner[c]] <= 1'b1;
            end
          end
          READ_RELAY: begin
            if (!consumer_read_valid[owner[c]]) begin
              state[c]                      <= IDLE;
              consumer_read_ready[owner[c]] <= 1'b0;
              busy[owner[c]]                <= 1'b0;
            end
          end
          WRITE_RELAY: begin
            if (!consumer_write_valid[owner[c]]) begin
              state[c]                       <= IDLE;
              consumer_write_ready[owner[c]] <= 1'b0;
              busy[owner[c]]                 <= 1'b0;
            end
          end
          default: state[c] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Randomized bench for lsu_mem_arbiter: consumer drivers, a latency-randomized memory,
// a cycle-level round-robin reference model and response scoreboards.
module tb_lsu_mem_arbiter;

  localparam int NC  = 4;
  localparam int NCH = 2;
  localparam int AW  = 8;
  localparam int DW  = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [NC-1:0]          rv, cr, wv, cw;
  logic [NC-1:0][AW-1:0]  ra, wa;
  logic [NC-1:0][DW-1:0]  cd, wd;
  logic [NCH-1:0]         mrv, mrr, mwv, mwr;
  logic [NCH-1:0][AW-1:0] mra, mwa;
  logic [NCH-1:0][DW-1:0] mrd, mwd;
  logic [NCH-1:0][2:0]    dbg;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]    mem_arr [256];
  logic [DW-1:0]    exp_rd_q [NC][$];
  logic [AW+DW-1:0] exp_wr_q [NC][$];
  int               wr_pending [NC];

  int lat_min = 1;
  int lat_max = 4;
  bit mem_stall = 1'b0;
  int cnt [NCH];

  // Reference model: which consumer each channel holds and what it is doing.
  int            m_owner [NCH];
  int            m_phase [NCH];
  bit            m_isrd  [NCH];
  logic [AW-1:0] m_addr  [NCH];
  logic [DW-1:0] m_data  [NCH];
  bit            m_new   [NCH];
  int            m_rel   [NCH];
  int            m_ptr;
  logic [NC-1:0] prev_cr, prev_cw, held, taken;

  lsu_mem_arbiter #(
    .NUM_CONSUMERS (NC),
    .NUM_CHANNELS  (NCH),
    .ADDR_BITS     (AW),
    .DATA_BITS     (DW)
  ) dut (
    .clk                    (clk),
    .reset                  (reset),
    .consumer_read_valid    (rv),
    .consumer_read_address  (ra),
    .consumer_read_ready    (cr),
    .consumer_read_data     (cd),
    .consumer_write_valid   (wv),
    .consumer_write_address (wa),
    .consumer_write_data    (wd),
    .consumer_write_ready   (cw),
    .mem_read_valid         (mrv),
    .mem_read_address       (mra),
    .mem_read_ready         (mrr),
    .mem_read_data          (mrd),
    .mem_write_valid        (mwv),
    .mem_write_address      (mwa),
    .mem_write_data         (mwd),
    .mem_write_ready        (mwr),
    .debug_chan_state       (dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  // ---------------- memory model ----------------
  initial begin
    mrr = '0;
    mwr = '0;
    mrd = '0;
    for (int c = 0; c < NCH; c++) cnt[c] = -1;
    forever begin
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (reset || mrr[c] || mwr[c] || !(mrv[c] || mwv[c])) begin
          mrr[c] = 1'b0;
          mwr[c] = 1'b0;
          cnt[c] = -1;
        end else if (!mem_stall) begin
          if (cnt[c] < 0) cnt[c] = int'($urandom_range(lat_max, lat_min)) - 1;
          if (cnt[c] == 0) begin
            if (mrv[c]) begin
              mrd[c] = mem_arr[mra[c]];
              mrr[c] = 1'b1;
            end else begin
              mwr[c] = 1'b1;
            end
          end else begin
            cnt[c]--;
          end
        end
      end
    end
  end

  // ---------------- monitor: reference model + scoreboard ----------------
  always @(negedge clk) begin : mon
    int k;
    int nptr;
    bit found;
    logic [AW+DW-1:0] e;
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_owner[c] = -1;
        m_phase[c] = 0;
        m_new[c]   = 1'b0;
        m_rel[c]   = -1;
      end
      m_ptr   = 0;
      prev_cr = '0;
      prev_cw = '0;
    end else begin
      // Compare what the last edge did against the model's prediction.
      for (int c = 0; c < NCH; c++) begin
        if (m_rel[c] >= 0) begin
          chk("release_ready_low", m_isrd[c] ? cr[m_rel[c]] : cw[m_rel[c]], 0);
          m_rel[c] = -1;
        end
        if (m_owner[c] < 0) begin
          chk("idle_chan_valids", {mrv[c], mwv[c]}, 0);
        end else if (m_phase[c] == 0) begin
          if (m_isrd[c]) begin
            chk("grant_read_valid", {mrv[c], mwv[c]}, 2'b10);
            chk("grant_read_addr", mra[c], m_addr[c]);
          end else begin
            chk("grant_write_valid", {mrv[c], mwv[c]}, 2'b01);
            chk("grant_write_addr", mwa[c], m_addr[c]);
            chk("grant_write_data", mwd[c], m_data[c]);
            if (m_new[c]) begin
              k = m_owner[c];
              if (exp_wr_q[k].size() == 0) begin
                chk("write_expected", 0, 1);
              end else begin
                e = exp_wr_q[k].pop_front();
                chk("write_payload", {mwa[c], mwd[c]}, e);
                wr_pending[k]++;
              end
            end
          end
        end else begin
          k = m_owner[c];
          chk("relay_mem_valid_low", {mrv[c], mwv[c]}, 0);
          chk("relay_ready_high", m_isrd[c] ? cr[k] : cw[k], 1);
        end
        m_new[c] = 1'b0;
      end

      for (int i = 0; i < NC; i++) begin
        if (cr[i] && !prev_cr[i]) begin
          if (exp_rd_q[i].size() == 0) chk("read_response_expected", 0, 1);
          else chk("read_data", cd[i], exp_rd_q[i].pop_front());
        end
        if (cw[i] && !prev_cw[i]) begin
          chk("write_response_expected", wr_pending[i] > 0, 1);
          if (wr_pending[i] > 0) wr_pending[i]--;
        end
      end
      prev_cr = cr;
      prev_cw = cw;

      // Predict the next edge: responses, releases, then rotating grants to free channels.
      held = '0;
      for (int c = 0; c < NCH; c++) if (m_owner[c] >= 0) held[m_owner[c]] = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        if (m_owner[c] >= 0) begin
          k = m_owner[c];
          if (m_phase[c] == 0) begin
            if (m_isrd[c] ? mrr[c] : mwr[c]) m_phase[c] = 1;
          end else if (m_isrd[c] ? !rv[k] : !wv[k]) begin
            m_rel[c] = k;
          end
        end
      end
      taken = '0;
      nptr  = m_ptr;
      for (int c = 0; c < NCH; c++) begin
        if (m_owner[c] < 0) begin
          found = 1'b0;
          for (int i = 0; i < NC; i++) begin
            k = (m_ptr + i) % NC;
            if (!found && (rv[k] || wv[k]) && !held[k] && !taken[k]) begin
              found      = 1'b1;
              taken[k]   = 1'b1;
              m_owner[c] = k;
              m_phase[c] = 0;
              m_isrd[c]  = rv[k];
              m_addr[c]  = rv[k] ? ra[k] : wa[k];
              m_data[c]  = wd[k];
              m_new[c]   = 1'b1;
              nptr       = (k + 1) % NC;
            end
          end
        end
      end
      m_ptr = nptr;
      for (int c = 0; c < NCH; c++) if (m_rel[c] >= 0) m_owner[c] = -1;
    end
  end

  // ---------------- driver tasks ----------------
  // kind: 0 read, 1 write, 2 read and write together.
  task automatic do_txn(input int k, input int kind, input logic [AW-1:0] ra_i,
                        input logic [AW-1:0] wa_i, input logic [DW-1:0] wd_i);
    int t;
    @(posedge clk);
    #1;
    if (kind != 1) begin
      ra[k] = ra_i;
      rv[k] = 1'b1;
      exp_rd_q[k].push_back(mem_arr[ra_i]);
    end
    if (kind != 0) begin
      wa[k] = wa_i;
      wd[k] = wd_i;
      wv[k] = 1'b1;
      exp_wr_q[k].push_back({wa_i, wd_i});
    end
    if (kind != 1) begin
      t = 0;
      while (!cr[k] && t < 400) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("read_ready_within_budget", cr[k], 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      rv[k] = 1'b0;
    end
    if (kind != 0) begin
      t = 0;
      while (!cw[k] && t < 400) begin
        @(posedge clk);
        #1;
        t++;
      end
      chk("write_ready_within_budget", cw[k], 1);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      wv[k] = 1'b0;
    end
  endtask

  task automatic consumer_thread(input int k, input int n);
    repeat (n) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_txn(k, int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 8'($urandom));
    end
  endtask

  task automatic reset_test();
    int t;
    t = 0;
    mem_stall = 1'b1;
    @(posedge clk);
    #1;
    ra[0] = 8'h21;
    rv[0] = 1'b1;
    while (mrv == '0 && t < 20) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("abort_read_granted", mrv != '0, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    rv[0]     = 1'b0;
    mem_stall = 1'b0;
    @(negedge clk);
    chk("abort_valids_ready_zero", {mrv, mwv, cr, cw}, 0);
    chk("abort_payload_zero", {mra, mwa, mwd}, 0);
    chk("abort_read_data_zero", cd, 0);
    chk("abort_fsm_idle", dbg, 0);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ready_pulse", {cr, cw}, 0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rv = '0;
    wv = '0;
    ra = '0;
    wa = '0;
    wd = '0;
    for (int i = 0; i < NC; i++) wr_pending[i] = 0;
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'($urandom);
    mem_arr[8'h3C] = 8'hA5;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset_valids_ready_zero", {mrv, mwv, cr, cw}, 0);
    chk("reset_payload_zero", {mra, mwa, mwd}, 0);
    chk("reset_read_data_zero", cd, 0);
    chk("reset_fsm_idle", dbg, 0);

    // Contention from rr_ptr = 0: expect c0/c1 first, then c2/c3.
    lat_min = 2;
    lat_max = 2;
    fork
      do_txn(0, 0, 8'h01, 8'h00, 8'h00);
      do_txn(1, 0, 8'h02, 8'h00, 8'h00);
      do_txn(2, 0, 8'h03, 8'h00, 8'h00);
      do_txn(3, 0, 8'h04, 8'h00, 8'h00);
    join

    lat_min = 3;
    lat_max = 3;
    do_txn(2, 0, 8'h3C, 8'h00, 8'h00);

    lat_min = 1;
    lat_max = 1;
    do_txn(1, 1, 8'h00, 8'h10, 8'h77);
    do_txn(3, 2, 8'h55, 8'h66, 8'h99);

    lat_min = 1;
    lat_max = 4;
    fork
      consumer_thread(0, 25);
      consumer_thread(1, 25);
      consumer_thread(2, 25);
      consumer_thread(3, 25);
    join

    reset_test();
    do_txn(0, 0, 8'h44, 8'h00, 8'h00);

    repeat (5) @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      chk("read_queue_drained", exp_rd_q[i].size(), 0);
      chk("write_queue_drained", exp_wr_q[i].size(), 0);
      chk("write_responses_matched", wr_pending[i], 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_arbiter.md
# lsu_mem_arbiter

Round-robin scheduler that shares a fixed pool of memory channels among a larger set of LSU/fetcher consumers. It sits between the per-core consumers and the data-memory cache/controller channel ports, and enforces a 4-phase valid/ready handshake on both sides. It guarantees each consumer is served by at most one channel at a time. Grants rotate fairly, so no consumer starves under sustained load.

## Interface
Parameters:
- NUM_CONSUMERS, 4, requesters (≥2)
- NUM_CHANNELS, 2, downstream channels (1..NUM_CONSUMERS)
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- consumer_read_valid  in  [NUM_CONSUMERS]  read request
- consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read done, data valid
- consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  read data
- consumer_write_valid  in  [NUM_CONSUMERS]  write request
- consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
- consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write done
- mem_read_valid / mem_read_address  out  [NUM_CHANNELS] / ADDR_BITS x NUM_CHANNELS  channel read request
- mem_read_ready / mem_read_data  in  [NUM_CHANNELS] / DATA_BITS x NUM_CHANNELS  channel read response
- mem_write_valid / mem_write_address / mem_write_data  out  per channel  channel write request
- mem_write_ready  in  [NUM_CHANNELS]  channel write done

## Operation
- Per-channel FSM:
  - IDLE -> READ_WAIT or WRITE_WAIT on grant.
  - READ_WAIT -> READ_RELAY on mem_read_ready.
  - WRITE_WAIT -> WRITE_RELAY on mem_write_ready.
  - *_RELAY -> IDLE when the served consumer's valid is low.
- Per-channel owner register (clog2 width) records the served consumer. A busy[NUM_CONSUMERS] vector marks consumers held by any channel.
- Eligible consumer: (read_valid | write_valid) & !busy.
- If a consumer asserts both read and write valid, read takes priority. The write stays pending.
- Grant, each cycle:
  - Channels are visited in ascending index.
  - Each IDLE channel takes the first eligible consumer at or after rr_ptr, wrapping modulo NUM_CONSUMERS.
  - Consumers granted earlier in the same cycle are excluded.
  - Two channels never grant the same consumer.
- rr_ptr advances to (last consumer granted this cycle + 1) mod NUM_CONSUMERS. It is unchanged if no grant occurs.
- On grant, the channel latches address and data into mem_* registers and asserts mem_*_valid.
- On mem ready: mem_*_valid drops. For reads, mem_read_data is captured into consumer_read_data[owner]. consumer_*_ready[owner] is set.
- In RELAY, ready is held until the consumer's valid drops. At that edge ready clears, busy[owner] clears, and the FSM returns to IDLE.
- consumer_read_data holds its last value until the next read completes for that consumer.
- mem_*_address and mem_write_data are don't-care when the matching valid is low. They are held stable while valid is high.

## Timing
- Reset: all outputs 0, all FSMs IDLE, busy = 0, rr_ptr = 0, owners = 0.
- Reset mid-transaction aborts immediately. No ready is issued for the aborted request.
- Grant latency: consumer valid high before edge N gives mem_*_valid high after edge N (one cycle).
- Response latency: mem ready high before edge M gives consumer ready high after edge M. mem valid is low after the same edge.
- mem_*_ready is sampled only in WAIT states. Ready asserted in any other state is ignored.
- Release: consumer valid low before edge R gives ready low and channel IDLE after R. The channel can grant again at edge R+1.
- A released consumer may re-request at R+1 and compete normally under rr_ptr.
- Simultaneous events in one cycle: a channel releasing and another channel granting are independent. A consumer being released by channel c is not eligible in that same cycle.
- All channels busy: requests wait with no loss. Consumer valid must stay high until ready (consumer obligation).

## Structure
- Shared package lsu_mem_pkg holds:
  - typedef enum chan_state_t {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY}
  - owner index width function
- Sub-module rr_priority_pick: purely combinational, (req vector, start pointer) -> one-hot grant + index + found.
  - Instantiated once per channel, chained via a masked request vector.

## Test plan
- Single read: consumer 2 reads 0x3C with NUM_CHANNELS=2.
  - ch0 shows mem_read_valid, address 0x3C, one cycle later.
  - Memory returns 0xA5 after 3 cycles; consumer_read_ready[2]=1 and data 0xA5 the next cycle.
  - Drop valid: ready clears in 1 cycle.
- Contention: all 4 consumers request the same cycle, 2 channels, memory latency 2.
  - First grants go to ch0←c0 and ch1←c1; rr_ptr becomes 2.
  - Next grants are c2 and c3; no consumer is served twice.
- Fairness: c0 re-requests immediately after every release while c3 requests continuously (1 channel).
  - c3 is granted within NUM_CONSUMERS grants; the grant order alternates c0, c3.
- Write: c1 writes 0x77 to 0x10.
  - mem_write_valid, 0x10, 0x77 next cycle; mem_write_ready gives consumer_write_ready[1] next cycle.
  - Read and write issued together by the same consumer are served read first.
- Reset mid-read: assert reset during READ_WAIT.
  - All outputs 0 the next cycle and no ready pulse.
  - A fresh request is granted normally after reset deasserts.
